fetch_pc_sequencer: RTL
=======================

# fetch_pc_sequencer

Owns the architectural fetch PC and sequences the instruction-memory request stream for the pipelined core. Resolved branch/jump targets from the PC-resolution logic in execute, stalls from the hazard unit, and HALT from writeback all feed this block. Each cycle it decides whether to advance, hold, redirect or stop the PC. It drains an in-flight, non-cancellable memory access before applying a redirect or halt.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hazard unit: do not advance PC this cycle.
- redirect_valid  in  1  execute resolved a taken branch or jump.
- redirect_pc  in  16  target PC, valid with redirect_valid.
- redirect_err  in  1  target-computation overflow, valid with redirect_valid.
- halt  in  1  HALT instruction reached writeback.
- imem_ready  in  1  instruction memory completes the current access this cycle.
- imem_req  out  1  access request; address must stay stable until imem_ready.
- imem_addr  out  16  fetch address.
- inst_valid  out  1  fetched instruction is delivered to IF/ID this cycle.
- pc_out  out  16  PC of the delivered instruction.
- pc_plus2  out  16  pc_out + 2, mod 2^16, used as link value.
- flush  out  1  kill younger instructions in IF/ID and ID/EX this cycle.
- halted  out  1  block is in HALTED.
- err  out  1  sticky error flag.

## Operation
- State register: pc[15:0], tgt[15:0], halt_pend, err, and FSM state in {IDLE, FETCH, DRAIN, HALTED}.
- Reset (async):
  - pc=RESET_PC, tgt=0, halt_pend=0, err=0, state=IDLE.
  - All outputs 0 except imem_addr=pc_out=RESET_PC and pc_plus2=RESET_PC+2.
- imem_addr = pc_out = pc at all times. pc_plus2 = pc + 2, wrapping 16'hFFFE to 16'h0000 without error.
- Accepted events:
  - acc_halt = halt & state!=HALTED.
  - acc_redir = redirect_valid & ~halt & state in {FETCH, DRAIN}.
  - Halt beats redirect because the HALT instruction is older.
- flush = acc_redir | acc_halt (combinational).
- IDLE:
  - imem_req=0.
  - Next state FETCH unconditionally. halt or redirect in IDLE are ignored; none can be in flight.
- FETCH:
  - imem_req=1.
  - inst_valid = imem_ready & ~stall & ~acc_redir & ~acc_halt.
  - acc_halt & imem_ready: go to HALTED.
  - acc_halt & ~imem_ready: halt_pend=1, go to DRAIN.
  - acc_redir & imem_ready: pc=redirect_pc, stay in FETCH.
  - acc_redir & ~imem_ready: tgt=redirect_pc, go to DRAIN.
  - Otherwise imem_ready & ~stall: pc=pc+2.
  - Otherwise imem_ready & stall: PC holds; the same address is re-fetched next cycle.
  - ~imem_ready: hold pc and keep the request asserted.
- DRAIN:
  - imem_req=1 at the old pc; inst_valid=0 and returned data is discarded.
  - A new acc_redir overwrites tgt. A new acc_halt sets halt_pend.
  - On imem_ready with halt_pend (or acc_halt this cycle): go to HALTED.
  - On imem_ready otherwise: pc = acc_redir ? redirect_pc : tgt, go to FETCH.
- HALTED:
  - imem_req=0, inst_valid=0, flush=0, halted=1.
  - All inputs ignored; only rst exits.
- err is set (sticky until rst) on acc_redir when redirect_pc[0]=1 or redirect_err=1. A misaligned target is still loaded, unmodified.

## Timing
- The first request appears in cycle 1 after rst deasserts (IDLE lasts exactly 1 cycle).
- With single-cycle memory (imem_ready=1) and no stall: one inst_valid per cycle, with pc_out = RESET_PC, +2, +4, ...
- Redirect in FETCH with imem_ready=1: flush is asserted in the same cycle, and the next cycle's imem_addr = redirect_pc. The redirect penalty is the flushed slots only.
- Redirect with memory busy: flush in the acceptance cycle. The first request to the target goes out the cycle after the draining imem_ready.
- Stall and redirect in the same cycle: the redirect wins.
- halted rises the cycle after the final imem_ready, or after acc_halt if memory is ready.
- rst asserted mid-access: imem_req drops immediately (async). The memory must tolerate abandonment on reset.

## Test plan
- Reset, then imem_ready=1 with no events for 4 cycles -> imem_addr 0x0000, 0x0002, 0x0004, 0x0006, and inst_valid=1 from cycle 1.
- At pc=0x0010, stall=1 for 2 cycles -> imem_addr holds 0x0010, inst_valid=0, then the sequence resumes at 0x0012.
- At pc=0x0020 with imem_ready=1, redirect_valid with redirect_pc=0x0100 -> flush=1 that cycle, next imem_addr=0x0100, err=0.
- imem_ready=0 at pc=0x0030, redirect to 0x0200, then a second redirect to 0x0300, then imem_ready=1 after 3 cycles -> inst_valid stays 0, flush pulses twice, and the next fetch is 0x0300.
- halt and redirect_valid (0x0400) in the same cycle with imem_ready=1 -> flush=1, halted=1 next cycle, imem_req=0, pc frozen; later stimulus is ignored until rst.
- Redirect to 0x0101 -> err=1 and pc=0x0101; err stays set through later traffic and clears only on rst. Fetch at 0xFFFE -> next fetch at 0x0000 with err unchanged.

Source files
------------

// File: rtl/fetch_pc_sequencer_if.sv
// Fetch sequencer bus: hazard/execute/writeback controls in, imem request and IF/ID delivery out.
interface fetch_pc_sequencer_if;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        redirect_err;
  logic        halt;
  logic        imem_ready;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        inst_valid;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        flush;
  logic        halted;
  logic        err;

  modport master (
    input  stall, redirect_valid, redirect_pc, redirect_err, halt, imem_ready,
    output imem_req, imem_addr, inst_valid, pc_out, pc_plus2, flush, halted, err
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, redirect_err, halt, imem_ready,
    input  imem_req, imem_addr, inst_valid, pc_out, pc_plus2, flush, halted, err
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Architectural fetch PC owner: advances, holds, redirects or halts the PC,
// draining any in-flight instruction-memory access before a redirect/halt takes effect.
module fetch_pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic                  clk,
  input logic                  rst,
  fetch_pc_sequencer_if.master bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]  state, stateNext;
  logic [15:0] pc, pcNext;
  logic [15:0] tgt, tgtNext;
  logic        haltPend, haltPendNext;
  logic        errQ, errNext;
  logic        accHalt, accRedir;
  logic        reqComb, validComb;

  // The HALT is older than any redirecting branch, so it takes priority.
  assign accHalt  = bus.halt & (state != HALTED);
  assign accRedir = bus.redirect_valid & ~bus.halt & ((state == FETCH) | (state == DRAIN));

  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    tgtNext      = tgt;
    haltPendNext = haltPend;
    reqComb      = 1'b0;
    validComb    = 1'b0;
    errNext      = errQ | (accRedir & (bus.redirect_pc[0] | bus.redirect_err));
    case (state)
      IDLE: stateNext = FETCH;
      FETCH: begin
        reqComb   = 1'b1;
        validComb = bus.imem_ready & ~bus.stall & ~accRedir & ~accHalt;
        if (accHalt) begin
          if (bus.imem_ready) begin
            stateNext = HALTED;
          end else begin
            haltPendNext = 1'b1;
            stateNext    = DRAIN;
          end
        end else if (accRedir) begin
          if (bus.imem_ready) begin
            pcNext = bus.redirect_pc;
          end else begin
            tgtNext   = bus.redirect_pc;
            stateNext = DRAIN;
          end
        end else if (bus.imem_ready && !bus.stall) begin
          pcNext = pc + 16'd2;
        end
      end
      DRAIN: begin
        // Address stays at the old pc until the non-cancellable access completes.
        reqComb = 1'b1;
        if (accRedir) tgtNext = bus.redirect_pc;
        if (accHalt) haltPendNext = 1'b1;
        if (bus.imem_ready) begin
          if (haltPend || accHalt) begin
            stateNext = HALTED;
          end else begin
            pcNext    = accRedir ? bus.redirect_pc : tgt;
            stateNext = FETCH;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      tgt      <= '0;
      haltPend <= 1'b0;
      errQ     <= 1'b0;
    end else begin
      state    <= stateNext;
      pc       <= pcNext;
      tgt      <= tgtNext;
      haltPend <= haltPendNext;
      errQ     <= errNext;
    end
  end

  assign bus.imem_req   = reqComb;
  assign bus.inst_valid = validComb;
  assign bus.imem_addr  = pc;
  assign bus.pc_out     = pc;
  assign bus.pc_plus2   = pc + 16'd2;
  assign bus.flush      = accRedir | accHalt;
  assign bus.halted     = (state == HALTED);
  assign bus.err        = errQ;
endmodule
